enemy_step_scheduler: RTL
=========================

# enemy_step_scheduler

Sequences the enemy movers on the playfield. Divides the VGA start-of-frame pulse by a level-dependent period. Once per period it runs a round-robin dispatch round, giving each enabled mover a one-cycle step strobe (its `timer_done`) plus a fresh 4-bit random direction nibble from an internal LFSR. It sits between the VGA timing generator, the game-state controller and the array of enemy movement blocks.

## Interface
- `NUM_MOVERS`, default 4: number of mover slots, legal 1..8.
- `BASE_PERIOD`, default 8: frames per step at level 0, legal 1..15.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; a seed of 0 is replaced by 16'h0001.
- `CLK`  in  1: system clock.
- `RESETn`  in  1: reset, asynchronous, active-low.
- `startOfFrame`  in  1: one-cycle pulse per video frame.
- `enable`  in  1: game running; low forces idle.
- `pause`  in  1: freezes frame counting.
- `level`  in  3: difficulty, 0..7.
- `mover_mask`  in  NUM_MOVERS: bit i=1 means mover i is alive and is strobed.
- `step_strobe`  out  NUM_MOVERS: one-hot or zero, registered; mover i's `timer_done`.
- `random_out`  out  4: direction nibble, valid in every cycle with a nonzero `step_strobe`.
- `busy`  out  1: high while in DISPATCH.
- `round_done`  out  1: one-cycle pulse after the last slot of a round.

## Operation
- **Period:** `period = max(1, BASE_PERIOD − level)`, computed in 5-bit unsigned. `level` is sampled when the threshold is tested.
- **Frame counter:** `frame_cnt`, 4 bits.
  - Increments on `startOfFrame` when `enable` is high and `pause` is low.
  - When the incremented value would equal `period`, it clears to 0 and a dispatch is requested.
- **FSM state IDLE:** outputs are 0. On a dispatch request, go to DISPATCH with `idx = 0`.
- **FSM state DISPATCH:** one slot per cycle, `idx` = 0..NUM_MOVERS−1.
  - If `mover_mask[idx]` = 1: `step_strobe[idx]` = 1, `random_out = lfsr[3:0]`, and the LFSR advances one step.
  - If `mover_mask[idx]` = 0: the slot is consumed, no strobe, LFSR holds.
  - After the last slot, pulse `round_done` and return to IDLE. If `pending` is set, clear it and start a new round instead.
- **pending flag:** a dispatch request raised during DISPATCH sets `pending`. Requests never queue deeper than one.
- **LFSR:** 16-bit Galois. Next value is `(lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`. It advances only on issued strobes.
- **Direction encoding** (consumed by the movers): 0–3 up, 4–7 down, 8–11 right, 12–15 left.
- **pause:** the frame counter holds and frame pulses are ignored. A round already in progress completes normally.
- **enable low:** takes effect on the next edge.
  - FSM goes to IDLE; `frame_cnt`, `idx` and `pending` clear.
  - Outputs go to 0.
  - LFSR holds its value.
- **mover_mask:** sampled per slot, so a change mid-round affects only the remaining slots.

## Timing
- **Reset values:** `step_strobe` = 0, `random_out` = 0, `busy` = 0, `round_done` = 0, FSM = IDLE, `frame_cnt` = 0, `idx` = 0, `pending` = 0, `lfsr` = `LFSR_SEED`.
- **Round timing:** a threshold-reaching `startOfFrame` at cycle t produces:
  - `busy` and the slot-0 strobe at t+1;
  - the slot-i strobe at t+1+i;
  - `round_done` at t+1+NUM_MOVERS, with `busy` low in that cycle.
  - A pending round restarts slot 0 at t+1+NUM_MOVERS; `busy` stays high and `round_done` still pulses.
- **Strobe spacing:** at most one strobe bit is high per cycle. `step_strobe` is never high for two consecutive cycles on the same mover.
- **Simultaneous events:**
  - `pause` and `startOfFrame` in the same cycle: the pulse is ignored.
  - `enable` falling in the same cycle as a threshold pulse: no round starts.

## Test plan
- **Period at level 0:** NUM_MOVERS=4, BASE_PERIOD=8, level=0, mask=4'b1111, 16 frame pulses → two rounds, each starting 1 cycle after the 8th and 16th pulses. Strobes are 0001, 0010, 0100, 1000 on consecutive cycles, then `round_done`.
- **Random sequence:** default seed, first round → `random_out` = 4'h1, 4'h0, 4'h8 for the first three strobes (LFSR ACE1 → E270 → 7138).
- **Level scaling:**
  - level=5 → a round every 3rd frame;
  - level=7 → a round every frame;
  - BASE_PERIOD=3, level=6 → a round every frame (clamp to 1).
- **Masked slots:** mask=4'b1010 → strobes only at slots 1 and 3 (t+2, t+4); `random_out` values are 4'h1 then 4'h0; `round_done` still at t+5.
- **Pause and enable:**
  - `pause` high for 20 frames → no rounds and `frame_cnt` unchanged.
  - `enable` dropped at slot 2 → no further strobes and `busy` low next cycle; the LFSR value is retained when `enable` returns.
- **Reset mid-round:** assert `RESETn` low during slot 1 → all outputs 0 immediately and the LFSR returns to ACE1. The next round starts from slot 0 after a full period.

Source files
------------

// File: rtl/enemy_step_scheduler_if.sv
// Handshake bundle between the game-state controller / VGA timing side
// (master) and the enemy step scheduler (slave).
interface enemy_step_scheduler_if #(
    parameter int NUM_MOVERS = 4
);
    logic                  startOfFrame;
    logic                  enable;
    logic                  pause;
    logic [2:0]            level;
    logic [NUM_MOVERS-1:0] mover_mask;
    logic [NUM_MOVERS-1:0] step_strobe;
    logic [3:0]            random_out;
    logic                  busy;
    logic                  round_done;

    modport master (
        output startOfFrame, enable, pause, level, mover_mask,
        input  step_strobe, random_out, busy, round_done
    );

    modport slave (
        input  startOfFrame, enable, pause, level, mover_mask,
        output step_strobe, random_out, busy, round_done
    );
endinterface

// File: rtl/enemy_step_scheduler.sv
// Enemy step scheduler: divides the frame pulse by a level-dependent period
// and, once per period, strobes each alive mover in turn with a fresh
// random direction nibble taken from a 16-bit Galois LFSR.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a dispatch request, all outputs low
// S_DISPATCH | visiting slot idx this cycle, one slot per cycle
//
// Outputs are registered from the next state so that slot 0 is visible in
// the cycle right after the threshold-reaching frame pulse.
module enemy_step_scheduler #(
    parameter int          NUM_MOVERS  = 4,
    parameter int          BASE_PERIOD = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    enemy_step_scheduler_if.slave bus
);
    localparam int               IDX_W    = (NUM_MOVERS > 1) ? $clog2(NUM_MOVERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVERS - 1);
    localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [4:0]       BASE5    = 5'(BASE_PERIOD);
    localparam logic [15:0]      TAPS     = 16'hB400;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_DISPATCH = 1'b1
    } state_t;

    state_t                state, state_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic                  pending, pending_d;
    logic                  round_end;
    logic [3:0]            frame_cnt;
    logic [4:0]            period;
    logic [4:0]            frame_inc;
    logic                  frame_ok;
    logic                  dispatch_req;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [NUM_MOVERS-1:0] strobe_d, strobe_q;
    logic [3:0]            rnd_d, rnd_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;

    // Period and threshold detection; a level above the base period clamps to 1.
    always_comb begin
        period       = ({2'b00, bus.level} >= BASE5) ? 5'd1 : (BASE5 - {2'b00, bus.level});
        frame_inc    = {1'b0, frame_cnt} + 5'd1;
        frame_ok     = bus.startOfFrame & bus.enable & ~bus.pause;
        dispatch_req = frame_ok & (frame_inc == period);
        lfsr_next    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    end

    // Frame counter: counts accepted frame pulses, wraps at the period.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            frame_cnt <= 4'd0;
        end else if (!bus.enable) begin
            frame_cnt <= 4'd0;
        end else if (frame_ok) begin
            frame_cnt <= dispatch_req ? 4'd0 : frame_inc[3:0];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= S_IDLE;
            idx     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            pending <= pending_d;
        end
    end

    // FSM next-state logic, including the one-deep pending request.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        pending_d = pending;
        round_end = 1'b0;
        if (!bus.enable) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            pending_d = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dispatch_req) begin
                        state_d = S_DISPATCH;
                        idx_d   = '0;
                    end
                end
                S_DISPATCH: begin
                    if (idx == LAST_IDX) begin
                        round_end = 1'b1;
                        idx_d     = '0;
                        if (pending || dispatch_req) begin
                            // Restart consumes one request; a fresh one arriving
                            // together with an already pending one stays queued.
                            state_d   = S_DISPATCH;
                            pending_d = pending & dispatch_req;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx + 1'b1;
                        if (dispatch_req) begin
                            pending_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FSM output logic, evaluated on the next state so outputs register in step.
    always_comb begin
        strobe_d = '0;
        rnd_d    = 4'h0;
        busy_d   = (state_d == S_DISPATCH);
        done_d   = round_end;
        if (state_d == S_DISPATCH && bus.mover_mask[idx_d]) begin
            strobe_d[idx_d] = 1'b1;
            rnd_d           = lfsr[3:0];
        end
    end

    // Output registers and LFSR; the LFSR only moves when a strobe is issued.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            strobe_q <= '0;
            rnd_q    <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lfsr     <= SEED;
        end else begin
            strobe_q <= strobe_d;
            rnd_q    <= rnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (|strobe_d) begin
                lfsr <= lfsr_next;
            end
        end
    end

    assign bus.step_strobe = strobe_q;
    assign bus.random_out  = rnd_q;
    assign bus.busy        = busy_q;
    assign bus.round_done  = done_q;
endmodule
